// File: rtl/tfc_cmd_decoder.sv
// TFC command decoder: BX counter with alignment check, stretched FE reset,
// delayed calibration pulse sequencer and snapshot/sync strobes.
module tfc_cmd_decoder #(
    parameter int TFC_WIDTH = 8,
    parameter int BX_NUM    = 3564,
    parameter int BXID_W    = 12,
    parameter int FERST_LEN = 4,
    parameter int CAL_LEN   = 2
) (
    input  logic                 main_clk,
    input  logic                 rst_n,
    input  logic [TFC_WIDTH-1:0] tfc_in,
    input  logic [7:0]           calib_delay,
    output logic [BXID_W-1:0]    bxid,
    output logic                 bx_locked,
    output logic                 bx_err,
    output logic [7:0]           bx_err_cnt,
    output logic                 fe_reset_o,
    output logic                 calib_pulse_o,
    output logic                 calib_drop,
    output logic                 snapshot_o,
    output logic                 sync_o
);

    localparam int FE_W  = $clog2(FERST_LEN + 1);
    localparam int CAL_W = $clog2(CAL_LEN + 1);

    typedef enum logic [1:0] {
        CAL_IDLE  = 2'd0,
        CAL_WAIT  = 2'd1,
        CAL_PULSE = 2'd2
    } cal_state_t;

    logic cmd_bxrst;
    logic cmd_ferst;
    logic cmd_calib;
    logic cmd_snap;
    logic cmd_sync;
    logic cmd_errclr;

    assign cmd_bxrst  = tfc_in[0];
    assign cmd_ferst  = tfc_in[1];
    assign cmd_calib  = tfc_in[2];
    assign cmd_snap   = tfc_in[3];
    assign cmd_sync   = tfc_in[4];
    assign cmd_errclr = tfc_in[5];

    generate
        if (TFC_WIDTH > 6) begin : g_spare
            logic unused_spare;
            assign unused_spare = ^tfc_in[TFC_WIDTH-1:6];
        end
    endgenerate

    logic bx_last;
    logic err_evt;

    assign bx_last = (bxid == BXID_W'(BX_NUM - 1));
    assign err_evt = cmd_bxrst & bx_locked & ~bx_last;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            bxid       <= '0;
            bx_locked  <= 1'b0;
            bx_err     <= 1'b0;
            bx_err_cnt <= '0;
        end else begin
            if (cmd_bxrst || bx_last) begin
                bxid <= '0;
            end else begin
                bxid <= bxid + 1'b1;
            end
            bx_locked <= bx_locked | cmd_bxrst;
            bx_err    <= err_evt;
            // clear beats a simultaneous error so software sees a clean zero
            if (cmd_errclr) begin
                bx_err_cnt <= '0;
            end else if (err_evt && bx_err_cnt != 8'hFF) begin
                bx_err_cnt <= bx_err_cnt + 8'd1;
            end
        end
    end

    logic [FE_W-1:0] fe_cnt;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_cnt     <= '0;
            fe_reset_o <= 1'b0;
        end else if (cmd_ferst) begin
            fe_cnt     <= FE_W'(FERST_LEN - 1);
            fe_reset_o <= 1'b1;
        end else if (fe_cnt != '0) begin
            fe_cnt     <= fe_cnt - 1'b1;
            fe_reset_o <= 1'b1;
        end else begin
            fe_reset_o <= 1'b0;
        end
    end

    cal_state_t       state;
    cal_state_t       state_nx;
    logic [7:0]       dly_cnt;
    logic [7:0]       dly_nx;
    logic [CAL_W-1:0] len_cnt;
    logic [CAL_W-1:0] len_nx;
    logic             drop_nx;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CAL_IDLE;
            dly_cnt       <= '0;
            len_cnt       <= '0;
            calib_pulse_o <= 1'b0;
            calib_drop    <= 1'b0;
        end else begin
            state         <= state_nx;
            dly_cnt       <= dly_nx;
            len_cnt       <= len_nx;
            calib_pulse_o <= (state_nx == CAL_PULSE);
            calib_drop    <= drop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dly_nx   = dly_cnt;
        len_nx   = len_cnt;
        drop_nx  = 1'b0;
        if (cmd_ferst) begin
            // abort has priority; a Calib in the same word is lost
            state_nx = CAL_IDLE;
            dly_nx   = '0;
            len_nx   = '0;
            drop_nx  = cmd_calib;
        end else begin
            unique case (state)
                CAL_IDLE: begin
                    if (cmd_calib) begin
                        if (calib_delay == 8'd0) begin
                            state_nx = CAL_PULSE;
                            len_nx   = CAL_W'(CAL_LEN - 1);
                        end else begin
                            state_nx = CAL_WAIT;
                            dly_nx   = calib_delay;
                        end
                    end
                end
                CAL_WAIT: begin
                    drop_nx = cmd_calib;
                    if (dly_cnt == 8'd1) begin
                        state_nx = CAL_PULSE;
                        dly_nx   = '0;
                        len_nx   = CAL_W'(CAL_LEN - 1);
                    end else begin
                        dly_nx = dly_cnt - 8'd1;
                    end
                end
                CAL_PULSE: begin
                    drop_nx = cmd_calib;
                    if (len_cnt == '0) begin
                        state_nx = CAL_IDLE;
                    end else begin
                        len_nx = len_cnt - 1'b1;
                    end
                end
                default: begin
                    state_nx = CAL_IDLE;
                    dly_nx   = '0;
                    len_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot_o <= 1'b0;
            sync_o     <= 1'b0;
        end else begin
            snapshot_o <= cmd_snap;
            sync_o     <= cmd_sync;
        end
    end

endmodule

// File: tb/tb_tfc_cmd_decoder.sv
// Bench for tfc_cmd_decoder: vector table, directed corner sequences and
// random command words against a timestamp-based reference model.
module tb_tfc_cmd_decoder;

    localparam int BX_NUM    = 3564;
    localparam int FERST_LEN = 4;
    localparam int CAL_LEN   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  tfc_in = '0;
    logic [7:0]  calib_delay = '0;
    logic [11:0] bxid;
    logic        bx_locked, bx_err, fe_reset_o;
    logic        calib_pulse_o, calib_drop, snapshot_o, sync_o;
    logic [7:0]  bx_err_cnt;

    tfc_cmd_decoder #(
        .TFC_WIDTH(8), .BX_NUM(BX_NUM), .BXID_W(12),
        .FERST_LEN(FERST_LEN), .CAL_LEN(CAL_LEN)
    ) dut (
        .main_clk(clk), .rst_n(rst_n), .tfc_in(tfc_in),
        .calib_delay(calib_delay), .bxid(bxid), .bx_locked(bx_locked),
        .bx_err(bx_err), .bx_err_cnt(bx_err_cnt), .fe_reset_o(fe_reset_o),
        .calib_pulse_o(calib_pulse_o), .calib_drop(calib_drop),
        .snapshot_o(snapshot_o), .sync_o(sync_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: t = current cycle index, base = cycle at which bxid was 0
    int t, base, errcnt, fe_last, ps, pend;
    bit locked, active;
    int e_bx, e_cnt;
    bit e_lock, e_err, e_fe, e_pulse, e_drop, e_snap, e_sync;

    typedef struct {
        logic [7:0] w;
        int bx;
        bit lock, err;
        int cnt;
        bit fe, pulse, drop, snap, sync;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
        end
    endtask

    task automatic model_init();
        t = 0; base = 0; errcnt = 0; fe_last = -1000;
        ps = 0; pend = -1; locked = 0; active = 0;
    endtask

    task automatic model_step(input logic [7:0] w);
        int cur;
        bit busy;
        cur  = (t - base) % BX_NUM;
        busy = active && (t <= pend);
        e_err = w[0] && locked && (cur != BX_NUM - 1);
        if (w[0]) begin
            locked = 1;
            base = t + 1;
        end
        if (w[5]) errcnt = 0;
        else if (e_err && errcnt < 255) errcnt++;
        if (w[1]) fe_last = t;
        e_drop = w[2] && (w[1] || busy);
        if (w[1]) active = 0;
        else if (w[2] && !busy) begin
            active = 1;
            ps = t + 1 + int'(calib_delay);
            pend = ps + CAL_LEN - 1;
        end
        t++;
        e_bx = (t - base) % BX_NUM;
        e_lock = locked;
        e_cnt = errcnt;
        e_fe = (t - fe_last >= 1) && (t - fe_last <= FERST_LEN);
        e_pulse = active && t >= ps && t <= pend;
        e_snap = w[3];
        e_sync = w[4];
    endtask

    task automatic step(input logic [7:0] w);
        tfc_in = w;
        model_step(w);
        @(posedge clk);
        #1;
        chk("bxid", int'(bxid), e_bx);
        chk("bx_locked", int'(bx_locked), int'(e_lock));
        chk("bx_err", int'(bx_err), int'(e_err));
        chk("bx_err_cnt", int'(bx_err_cnt), e_cnt);
        chk("fe_reset_o", int'(fe_reset_o), int'(e_fe));
        chk("calib_pulse_o", int'(calib_pulse_o), int'(e_pulse));
        chk("calib_drop", int'(calib_drop), int'(e_drop));
        chk("snapshot_o", int'(snapshot_o), int'(e_snap));
        chk("sync_o", int'(sync_o), int'(e_sync));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tfc_in = '0;
        #1;
        chk("rst_bxid", int'(bxid), 0);
        chk("rst_locked", int'(bx_locked), 0);
        chk("rst_err", int'(bx_err), 0);
        chk("rst_cnt", int'(bx_err_cnt), 0);
        chk("rst_fe", int'(fe_reset_o), 0);
        chk("rst_pulse", int'(calib_pulse_o), 0);
        chk("rst_drop", int'(calib_drop), 0);
        chk("rst_snap", int'(snapshot_o), 0);
        chk("rst_sync", int'(sync_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_init();
    endtask

    initial begin
        logic [7:0] fe_w[8];
        bit         fe_e[8];
        logic [7:0] w;

        tbl[0]  = '{8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{8'h08, 2, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[2]  = '{8'h18, 3, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[3]  = '{8'h01, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{8'h02, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{8'h04, 2, 1, 0, 0, 1, 1, 0, 0, 0};
        tbl[6]  = '{8'h04, 3, 1, 0, 0, 1, 1, 1, 0, 0};
        tbl[7]  = '{8'h00, 4, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{8'h06, 5, 1, 0, 0, 1, 0, 1, 0, 0};
        tbl[9]  = '{8'h00, 6, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[10] = '{8'h01, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        tbl[11] = '{8'h20, 1, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[12] = '{8'h00, 2, 1, 0, 0, 0, 0, 0, 0, 0};

        #2;
        calib_delay = 8'd0;
        reset_dut();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].w);
            chk("tbl_bxid", int'(bxid), tbl[i].bx);
            chk("tbl_locked", int'(bx_locked), int'(tbl[i].lock));
            chk("tbl_err", int'(bx_err), int'(tbl[i].err));
            chk("tbl_cnt", int'(bx_err_cnt), tbl[i].cnt);
            chk("tbl_fe", int'(fe_reset_o), int'(tbl[i].fe));
            chk("tbl_pulse", int'(calib_pulse_o), int'(tbl[i].pulse));
            chk("tbl_drop", int'(calib_drop), int'(tbl[i].drop));
            chk("tbl_snap", int'(snapshot_o), int'(tbl[i].snap));
            chk("tbl_sync", int'(sync_o), int'(tbl[i].sync));
        end

        // orbit alignment: BXReset at cycle 10 then once per orbit
        reset_dut();
        repeat (10) step(8'h00);
        step(8'h01);
        chk("orbit_lock", int'(bx_locked), 1);
        for (int k = 0; k < 2; k++) begin
            repeat (BX_NUM - 1) step(8'h00);
            chk("orbit_last", int'(bxid), BX_NUM - 1);
            step(8'h01);
            chk("orbit_bxid", int'(bxid), 0);
            chk("orbit_err", int'(bx_err), 0);
        end

        // misaligned BXReset, saturation, clear
        repeat (100) step(8'h00);
        chk("mis_pre_bxid", int'(bxid), 100);
        step(8'h01);
        chk("mis_err", int'(bx_err), 1);
        chk("mis_cnt", int'(bx_err_cnt), 1);
        chk("mis_bxid", int'(bxid), 0);
        step(8'h00);
        chk("mis_err_clr", int'(bx_err), 0);
        repeat (300) step(8'h01);
        chk("sat_cnt", int'(bx_err_cnt), 255);
        step(8'h20);
        chk("clr_cnt", int'(bx_err_cnt), 0);
        step(8'h21);
        chk("clr_win_err", int'(bx_err), 1);
        chk("clr_win_cnt", int'(bx_err_cnt), 0);

        // FEReset retrigger
        fe_w = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        fe_e = '{1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            step(fe_w[i]);
            chk("fe_win", int'(fe_reset_o), int'(fe_e[i]));
        end

        // delayed calibration with a dropped second request
        calib_delay = 8'd5;
        for (int i = 0; i < 9; i++) begin
            step((i == 0 || i == 3) ? 8'h04 : 8'h00);
            chk("cal5_pulse", int'(calib_pulse_o), (i == 5 || i == 6) ? 1 : 0);
            chk("cal5_drop", int'(calib_drop), (i == 3) ? 1 : 0);
        end

        // zero delay, then abort during WAIT
        calib_delay = 8'd0;
        step(8'h04);
        chk("cal0_p1", int'(calib_pulse_o), 1);
        step(8'h00);
        chk("cal0_p2", int'(calib_pulse_o), 1);
        step(8'h00);
        chk("cal0_p3", int'(calib_pulse_o), 0);
        calib_delay = 8'd5;
        step(8'h04);
        step(8'h00);
        step(8'h02);
        for (int i = 0; i < 8; i++) begin
            step(8'h00);
            chk("abort_pulse", int'(calib_pulse_o), 0);
        end
        step(8'h04);
        chk("abort_idle_nodrop", int'(calib_drop), 0);
        repeat (8) step(8'h00);

        // asynchronous reset in the middle of pulse and FE window
        calib_delay = 8'd0;
        step(8'h02);
        step(8'h04);
        chk("mid_pulse", int'(calib_pulse_o), 1);
        chk("mid_fe", int'(fe_reset_o), 1);
        #2;
        reset_dut();

        // random command words
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) calib_delay = 8'($urandom_range(0, 12));
            w = 8'($urandom) & 8'hC0;
            if ($urandom_range(0, 63) == 0) w[0] = 1'b1;
            if ($urandom_range(0, 31) == 0) w[1] = 1'b1;
            if ($urandom_range(0, 7) == 0)  w[2] = 1'b1;
            if ($urandom_range(0, 3) == 0)  w[3] = 1'b1;
            if ($urandom_range(0, 3) == 0)  w[4] = 1'b1;
            if ($urandom_range(0, 31) == 0) w[5] = 1'b1;
            step(w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
